// File: rtl/d16_fetch_unit.sv
// d16 fetch front end: prefetch queue pairing two-word instructions; zero added latency from queue head, decoder backpressure stops fetch when full.
// Optional D16_FETCH_PERF_EN adds perf_stall, a saturating count of decoder-starved cycles.
module d16_fetch_unit #(
    parameter int                 DATA_W   = 16,
    parameter int                 ADDR_W   = 16,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_wait,
    input  logic [DATA_W-1:0]        mem_data,
    input  logic                     flush,
    input  logic [ADDR_W-1:0]        flush_pc,
    output logic                     insn_valid,
    input  logic                     insn_ready,
    output logic [DATA_W-1:0]        insn,
    output logic [DATA_W-1:0]        insn_imm,
    output logic [ADDR_W-1:0]        insn_pc,
    output logic [$clog2(DEPTH):0]   q_count
`ifdef D16_FETCH_PERF_EN
    ,
    output logic [15:0]              perf_stall
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] PC0 = RESET_PC & ~ADDR_W'(1);

    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_FULL} state_t;

    state_t              r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_q_dat [DEPTH];
    logic [ADDR_W-1:0]   r_q_pc  [DEPTH];
    logic [PW-1:0]       r_rd_ptr, r_wr_ptr;
    logic [CW-1:0]       r_count;
    logic [ADDR_W-1:0]   r_pc;

    logic                w_two, w_accept, w_pop;
    logic [PW-1:0]       w_rd_nxt;
    logic [CW-1:0]       w_pop_n, w_count_nxt;

    assign w_rd_nxt   = r_rd_ptr + PW'(1);
    assign w_two      = r_q_dat[r_rd_ptr][DATA_W-1];
    // A two-word head is only offered once its immediate is queued, so a pop never splits it.
    assign insn_valid = w_two ? (r_count >= CW'(2)) : (r_count != '0);
    assign insn       = r_q_dat[r_rd_ptr];
    assign insn_pc    = r_q_pc[r_rd_ptr];
    assign insn_imm   = w_two ? r_q_dat[w_rd_nxt] : '0;
    assign q_count    = r_count;
    assign mem_addr   = {1'b0, r_pc[ADDR_W-1:1]};

    assign w_accept    = mem_req && !mem_wait && !flush;
    assign w_pop       = insn_valid && insn_ready && !flush;
    assign w_pop_n     = w_pop ? (w_two ? CW'(2) : CW'(1)) : '0;
    assign w_count_nxt = r_count + {{(CW-1){1'b0}}, w_accept} - w_pop_n;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_BOOT;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_FETCH;
        end else begin
            case (r_state)
                S_BOOT:  w_state_nxt = S_FETCH;
                S_FETCH: if (w_count_nxt == CW'(DEPTH)) w_state_nxt = S_FULL;
                S_FULL:  if (w_pop) w_state_nxt = S_FETCH;
                default: w_state_nxt = S_BOOT;
            endcase
        end
    end

    // Registered-only request: a pop in the full cycle cannot reopen fetch until the next cycle.
    always_comb begin
        mem_req = (r_state == S_FETCH) && (r_count < CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_pc     <= PC0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_dat[i] <= '0;
                r_q_pc[i]  <= '0;
            end
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_pc     <= flush_pc & ~ADDR_W'(1);
        end else begin
            if (w_accept) begin
                r_q_dat[r_wr_ptr] <= mem_data;
                r_q_pc[r_wr_ptr]  <= r_pc;
                r_wr_ptr          <= r_wr_ptr + PW'(1);
                r_pc              <= r_pc + ADDR_W'(2);
            end
            r_rd_ptr <= r_rd_ptr + w_pop_n[PW-1:0];
            r_count  <= w_count_nxt;
        end
    end

`ifdef D16_FETCH_PERF_EN
    logic [15:0] r_perf_stall;
    always_ff @(posedge clk) begin
        if (rst)
            r_perf_stall <= '0;
        else if (insn_ready && !insn_valid && (r_perf_stall != 16'hFFFF))
            r_perf_stall <= r_perf_stall + 16'd1;
    end
    assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_d16_fetch_unit.sv
// Directed bench: main DEPTH=4 instance from PC 0, plus a DEPTH=2 instance from PC 0xFFFC for wrap and pair-drain cases.
module tb_d16_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mem_req, mem_wait, flush, insn_valid, insn_ready;
    logic [15:0] mem_addr, mem_data, flush_pc, insn, insn_imm, insn_pc;
    logic [2:0]  q_count;

    logic        w_mem_req, w_mem_wait, w_flush, w_insn_valid, w_insn_ready;
    logic [15:0] w_mem_addr, w_mem_data, w_flush_pc, w_insn, w_insn_imm, w_insn_pc;
    logic [1:0]  w_q_count;
`ifdef D16_FETCH_PERF_EN
    logic [15:0] perf_stall, w_perf_stall;
`endif

    logic [15:0] mem_img [64];
    assign mem_data   = mem_img[mem_addr[5:0]];
    assign w_mem_data = mem_img[w_mem_addr[5:0]];

    d16_fetch_unit #(.DATA_W(16), .ADDR_W(16), .DEPTH(4), .RESET_PC(16'h0000)) u_dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wait(mem_wait), .mem_data(mem_data),
        .flush(flush), .flush_pc(flush_pc),
        .insn_valid(insn_valid), .insn_ready(insn_ready),
        .insn(insn), .insn_imm(insn_imm), .insn_pc(insn_pc),
        .q_count(q_count)
`ifdef D16_FETCH_PERF_EN
        , .perf_stall(perf_stall)
`endif
    );

    d16_fetch_unit #(.DATA_W(16), .ADDR_W(16), .DEPTH(2), .RESET_PC(16'hFFFC)) u_wrap (
        .clk(clk), .rst(rst),
        .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_wait(w_mem_wait), .mem_data(w_mem_data),
        .flush(w_flush), .flush_pc(w_flush_pc),
        .insn_valid(w_insn_valid), .insn_ready(w_insn_ready),
        .insn(w_insn), .insn_imm(w_insn_imm), .insn_pc(w_insn_pc),
        .q_count(w_q_count)
`ifdef D16_FETCH_PERF_EN
        , .perf_stall(w_perf_stall)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 64; k++) begin
            mem_img[k] = {8'(k + 1), 8'(k + 1)};
        end
        mem_img[10] = 16'h8123;
        mem_img[11] = 16'hBEEF;

        rst = 1'b1;
        mem_wait = 1'b0; flush = 1'b0; flush_pc = '0; insn_ready = 1'b0;
        w_mem_wait = 1'b0; w_flush = 1'b0; w_flush_pc = '0; w_insn_ready = 1'b0;
        repeat (3) tick();

        check("rst_q_count",    32'(q_count),    0);
        check("rst_mem_req",    32'(mem_req),    0);
        check("rst_insn_valid", 32'(insn_valid), 0);
        check("rst_insn",       32'(insn),       0);
        check("rst_mem_addr",   32'(mem_addr),   0);
        check("rst_w_mem_req",  32'(w_mem_req),  0);

        // Streaming with the decoder always ready
        rst = 1'b0; insn_ready = 1'b1; w_insn_ready = 1'b1;
        tick();
        check("boot_valid",   32'(insn_valid), 0);
        check("boot_req",     32'(mem_req),    1);
        check("boot_addr",    32'(mem_addr),   0);
        tick();
        check("s0_valid",     32'(insn_valid), 1);
        check("s0_insn",      32'(insn),       32'h0101);
        check("s0_pc",        32'(insn_pc),    0);
        check("s0_imm",       32'(insn_imm),   0);
        check("s0_count",     32'(q_count),    1);
        check("wrap0_pc",     32'(w_insn_pc),  32'hFFFC);
        check("wrap0_insn",   32'(w_insn),     32'h3F3F);
        tick();
        check("s1_pc",        32'(insn_pc),    2);
        check("s1_insn",      32'(insn),       32'h0202);
        check("wrap1_pc",     32'(w_insn_pc),  32'hFFFE);
        tick();
        check("s2_pc",        32'(insn_pc),    4);
        check("s2_insn",      32'(insn),       32'h0303);
        check("wrap2_pc",     32'(w_insn_pc),  32'h0000);
        check("wrap2_insn",   32'(w_insn),     32'h0101);

        // Fill to full; DEPTH=2 instance redirected onto the 0x8123/0xBEEF pair
        insn_ready = 1'b0; w_insn_ready = 1'b0;
        w_flush = 1'b1; w_flush_pc = 16'h0014;
        tick();
        w_flush = 1'b0;
        repeat (3) tick();
        check("full_count",   32'(q_count),    4);
        check("full_req",     32'(mem_req),    0);
        check("full_addr",    32'(mem_addr),   6);
        check("full_pc",      32'(insn_pc),    4);
        check("full_valid",   32'(insn_valid), 1);
        check("d2_count",     32'(w_q_count),  2);
        check("d2_valid",     32'(w_insn_valid), 1);
        check("d2_insn",      32'(w_insn),     32'h8123);
        check("d2_imm",       32'(w_insn_imm), 32'hBEEF);
        check("d2_req",       32'(w_mem_req),  0);

        insn_ready = 1'b1; w_insn_ready = 1'b1;
        tick();
        check("rel_count",    32'(q_count),    3);
        check("rel_req",      32'(mem_req),    1);
        check("rel_pc",       32'(insn_pc),    6);
        check("d2_pop_count", 32'(w_q_count),  0);
        check("d2_pop_valid", 32'(w_insn_valid), 0);
        check("d2_pop_req",   32'(w_mem_req),  1);
        check("d2_pop_addr",  32'(w_mem_addr), 32'h000C);

        insn_ready = 1'b0; w_insn_ready = 1'b0;
        tick();
        check("refull_count", 32'(q_count),    4);
        check("refull_req",   32'(mem_req),    0);
        check("refull_addr",  32'(mem_addr),   7);

        // Stalled memory
        insn_ready = 1'b1; mem_wait = 1'b1;
        tick();
        check("wait_pop_count", 32'(q_count),  3);
        check("wait_req",     32'(mem_req),    1);
        insn_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_count", 32'(q_count),  3);
            check("wait_addr",  32'(mem_addr), 7);
        end
        mem_wait = 1'b0;
        tick();
        check("unwait_count", 32'(q_count),    4);
        check("unwait_addr",  32'(mem_addr),   8);

        // Flush with 3 queued, an accept and a pop in the same cycle
        insn_ready = 1'b1;
        tick();
        check("pre_fl_count", 32'(q_count),    3);
        check("pre_fl_req",   32'(mem_req),    1);
        flush = 1'b1; flush_pc = 16'h0041;
        tick();
        flush = 1'b0;
        check("fl_count",     32'(q_count),    0);
        check("fl_addr",      32'(mem_addr),   32'h0020);
        check("fl_valid",     32'(insn_valid), 0);
        tick();
        check("fl_next_valid", 32'(insn_valid), 1);
        check("fl_next_pc",   32'(insn_pc),    32'h0040);
        check("fl_next_insn", 32'(insn),       32'h2121);

        // Two-word pairing on the DEPTH=4 instance
        flush = 1'b1; flush_pc = 16'h0014; insn_ready = 1'b0;
        tick();
        flush = 1'b0;
        check("pr_fl_count",  32'(q_count),    0);
        tick();
        check("pr_half_valid", 32'(insn_valid), 0);
        check("pr_half_count", 32'(q_count),   1);
        tick();
        check("pr_valid",     32'(insn_valid), 1);
        check("pr_insn",      32'(insn),       32'h8123);
        check("pr_imm",       32'(insn_imm),   32'hBEEF);
        check("pr_pc",        32'(insn_pc),    32'h0014);
        check("pr_count",     32'(q_count),    2);
        insn_ready = 1'b1; mem_wait = 1'b1;
        tick();
        check("pr_pop_count", 32'(q_count),    0);
        check("pr_pop_valid", 32'(insn_valid), 0);

        // Reset with a stalled request outstanding
        rst = 1'b1;
        tick();
        check("mid_rst_count", 32'(q_count),   0);
        check("mid_rst_req",  32'(mem_req),    0);
        check("mid_rst_valid", 32'(insn_valid), 0);
        check("mid_rst_addr", 32'(mem_addr),   0);
        check("mid_rst_pc",   32'(insn_pc),    0);
`ifdef D16_FETCH_PERF_EN
        check("perf_rst",     32'(perf_stall), 0);
        rst = 1'b0; insn_ready = 1'b1; mem_wait = 1'b1;
        repeat (5) tick();
        check("perf_stall5",  32'(perf_stall), 5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
